// File: rtl/kbd_joy_decoder.sv
// PS/2 set-2 scancode decoder producing a 13-bit pressed-key vector (BCPPFRLDU order).
// Optional macro KBD_AUTOFIRE_EN gates the fire bit with a free-running autofire phase.
module kbd_joy_decoder #(
  parameter int unsigned AUTOFIRE_DIV = 500000
) (
  input  logic        clk_i,
  input  logic        res_n_i,
  input  logic        kbdint_i,
  input  logic [7:0]  scancode_i,
  output logic [12:0] joy_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_EXT,
    S_BRK,
    S_EXT_BRK,
    S_SKIP
  } state_t;

  state_t      state_q, state_d;
  logic [2:0]  skip_cnt_q, skip_cnt_d;
  logic [12:0] keys_q, keys_d;

  // One-hot mask of the key addressed by (code, ext); zero when the code is not mapped.
  function automatic logic [12:0] key_map(input logic [7:0] code, input logic ext);
    logic [12:0] m;
    m = '0;
    case (code)
      8'h75: m[0]  = ext;
      8'h72: m[1]  = ext;
      8'h6B: m[2]  = ext;
      8'h74: m[3]  = ext;
      8'h29: m[4]  = ~ext;
      8'h14: m[4]  = 1'b1;
      8'h16: m[5]  = ~ext;
      8'h1E: m[6]  = ~ext;
      8'h2E: m[7]  = ~ext;
      8'h11: m[8]  = 1'b1;
      8'h07: m[9]  = ~ext;
      8'h04: m[10] = ~ext;
      8'h4D: m[11] = ~ext;
      8'h0D: m[12] = ~ext;
      default: m = '0;
    endcase
    return m;
  endfunction

  always_comb begin
    logic        do_make;
    logic        do_brk;
    logic        ext;
    logic [12:0] mask;
    state_d    = state_q;
    skip_cnt_d = skip_cnt_q;
    keys_d     = keys_q;
    do_make    = 1'b0;
    do_brk     = 1'b0;
    ext        = 1'b0;
    if (kbdint_i) begin
      case (state_q)
        S_IDLE: begin
          case (scancode_i)
            8'hE0: state_d = S_EXT;
            8'hF0: state_d = S_BRK;
            8'hE1: begin
              state_d    = S_SKIP;
              skip_cnt_d = 3'd7;
            end
            8'hAA, 8'h00, 8'hFF: keys_d = '0;
            8'hFA, 8'hFE: ;
            default: do_make = 1'b1;
          endcase
        end
        S_EXT: begin
          case (scancode_i)
            8'hF0: state_d = S_EXT_BRK;
            8'hE0: state_d = S_EXT;
            default: begin
              do_make = 1'b1;
              ext     = 1'b1;
              state_d = S_IDLE;
            end
          endcase
        end
        S_BRK: begin
          if (scancode_i == 8'hE0) begin
            state_d = S_EXT;
          end else begin
            do_brk  = 1'b1;
            state_d = S_IDLE;
          end
        end
        S_EXT_BRK: begin
          do_brk  = 1'b1;
          ext     = 1'b1;
          state_d = S_IDLE;
        end
        S_SKIP: begin
          skip_cnt_d = skip_cnt_q - 3'd1;
          if (skip_cnt_q == 3'd1) state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
    mask = key_map(scancode_i, ext);
    if (do_make) keys_d = keys_q | mask;
    if (do_brk)  keys_d = keys_q & ~mask;
  end

  always_ff @(posedge clk_i or negedge res_n_i) begin
    if (!res_n_i) begin
      state_q    <= S_IDLE;
      skip_cnt_q <= '0;
      keys_q     <= '0;
    end else begin
      state_q    <= state_d;
      skip_cnt_q <= skip_cnt_d;
      keys_q     <= keys_d;
    end
  end

`ifdef KBD_AUTOFIRE_EN
  localparam logic [23:0] AF_LAST = 24'(AUTOFIRE_DIV - 1);

  logic [23:0] af_cnt_q, af_cnt_d;
  logic        af_phase_q, af_phase_d;

  // A fresh press restarts at phase 1 so the first shot fires immediately.
  always_comb begin
    af_cnt_d   = af_cnt_q;
    af_phase_d = af_phase_q;
    if (!keys_d[4]) begin
      af_cnt_d   = '0;
      af_phase_d = 1'b0;
    end else if (!keys_q[4]) begin
      af_cnt_d   = '0;
      af_phase_d = 1'b1;
    end else if (af_cnt_q == AF_LAST) begin
      af_cnt_d   = '0;
      af_phase_d = ~af_phase_q;
    end else begin
      af_cnt_d   = af_cnt_q + 24'd1;
    end
  end

  always_ff @(posedge clk_i or negedge res_n_i) begin
    if (!res_n_i) begin
      af_cnt_q   <= '0;
      af_phase_q <= 1'b0;
    end else begin
      af_cnt_q   <= af_cnt_d;
      af_phase_q <= af_phase_d;
    end
  end

  assign joy_o = {keys_q[12:5], keys_q[4] & af_phase_q, keys_q[3:0]};
`else
  assign joy_o = keys_q;
`endif

endmodule

// File: tb/tb_kbd_joy_decoder.sv
// Self-checking bench for kbd_joy_decoder: expected key vectors are queued per strobe
// and compared after the decode edge.
module tb_kbd_joy_decoder;

  logic        clk;
  logic        res_n;
  logic        kbdint;
  logic [7:0]  scancode;
  logic [12:0] joy;

  logic [12:0] exp_q[$];
  int          n_chk;
  int          n_fail;

  kbd_joy_decoder #(.AUTOFIRE_DIV(4)) dut (
    .clk_i      (clk),
    .res_n_i    (res_n),
    .kbdint_i   (kbdint),
    .scancode_i (scancode),
    .joy_o      (joy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Called at a falling edge; returns at the falling edge after the capture edge.
  task automatic strobe(input logic [7:0] b);
    kbdint   = 1'b1;
    scancode = b;
    @(posedge clk);
    @(negedge clk);
    kbdint   = 1'b0;
  endtask

  task automatic test_reset;
    logic [12:0] e;
    res_n = 1'b0;
    kbdint = 1'b0;
    scancode = 8'h00;
    repeat (2) @(negedge clk);
    n_chk++;
    if (joy !== 13'h0000) begin
      n_fail++;
      $display("FAIL reset_initial: got %h want %h", joy, 13'h0000);
    end
    res_n = 1'b1;
    @(negedge clk);
    exp_q.push_back(13'h0010);
    strobe(8'h29);
    exp_q.push_back(13'h0010);
    strobe(8'hE0);
    for (int i = 0; i < 2; i++) begin
      e = exp_q.pop_front();
      n_chk++;
      if (joy !== e && i == 1) begin
        n_fail++;
        $display("FAIL reset_pre: got %h want %h", joy, e);
      end
    end
    // Async clear mid-cycle, with an E0 prefix pending.
    #2 res_n = 1'b0;
    #1;
    n_chk++;
    if (joy !== 13'h0000) begin
      n_fail++;
      $display("FAIL reset_async: got %h want %h", joy, 13'h0000);
    end
    @(negedge clk);
    res_n = 1'b1;
    @(negedge clk);
    exp_q.push_back(13'h0000);
    strobe(8'h75);
    e = exp_q.pop_front();
    n_chk++;
    if (joy !== e) begin
      n_fail++;
      $display("FAIL reset_prefix_dropped: got %h want %h", joy, e);
    end
    exp_q.push_back(13'h0010);
    strobe(8'h29);
    e = exp_q.pop_front();
    n_chk++;
    if (joy !== e) begin
      n_fail++;
      $display("FAIL reset_first_make: got %h want %h", joy, e);
    end
    strobe(8'hAA);
  endtask

  task automatic test_seq(input string name, input logic [7:0] bytes[], input logic [12:0] exps[]);
    logic [12:0] e;
    for (int i = 0; i < bytes.size(); i++) begin
      exp_q.push_back(exps[i]);
      strobe(bytes[i]);
      e = exp_q.pop_front();
      n_chk++;
      if (joy !== e) begin
        n_fail++;
        $display("FAIL %s[%0d] byte %h: got %h want %h", name, i, bytes[i], joy, e);
      end
    end
  endtask

  task automatic test_make_break;
    test_seq("make_break",
      '{8'h29, 8'h2E, 8'hF0, 8'h29, 8'hF0, 8'h2E, 8'h29, 8'h29, 8'hF0, 8'h29, 8'hF0, 8'h29},
      '{13'h0010, 13'h0090, 13'h0090, 13'h0080, 13'h0080, 13'h0000,
        13'h0010, 13'h0010, 13'h0010, 13'h0000, 13'h0000, 13'h0000});
  endtask

  task automatic test_extended;
    test_seq("extended",
      '{8'hE0, 8'h75, 8'h75, 8'hE0, 8'hF0, 8'h75, 8'h74, 8'hE0, 8'h14, 8'hE0, 8'hF0, 8'h14,
        8'hF0, 8'hE0, 8'h75, 8'hE0, 8'hE0, 8'h72, 8'hFF},
      '{13'h0000, 13'h0001, 13'h0001, 13'h0001, 13'h0001, 13'h0000, 13'h0000, 13'h0000,
        13'h0010, 13'h0010, 13'h0010, 13'h0000,
        13'h0000, 13'h0000, 13'h0001, 13'h0001, 13'h0001, 13'h0003, 13'h0000});
  endtask

  task automatic test_back_to_back_pause;
    test_seq("pause",
      '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77, 8'h14, 8'hF0, 8'h14},
      '{13'h0000, 13'h0000, 13'h0000, 13'h0000, 13'h0000, 13'h0000, 13'h0000, 13'h0000,
        13'h0010, 13'h0010, 13'h0000});
  endtask

  task automatic test_hotplug_system;
    test_seq("hotplug",
      '{8'h16, 8'h1E, 8'hE0, 8'h6B, 8'hAA, 8'hF0, 8'h16,
        8'h07, 8'h04, 8'h4D, 8'h0D, 8'h11, 8'hFA, 8'hE0, 8'h11, 8'hFE, 8'h00},
      '{13'h0020, 13'h0060, 13'h0060, 13'h0064, 13'h0000, 13'h0000, 13'h0000,
        13'h0200, 13'h0600, 13'h0E00, 13'h1E00, 13'h1F00, 13'h1F00, 13'h1F00, 13'h1F00,
        13'h1F00, 13'h0000});
  endtask

  task automatic test_autofire;
    logic [12:0] e;
    exp_q.push_back(13'h0010);
    strobe(8'h29);
    for (int i = 0; i < 13; i++) begin
      e = exp_q.pop_front();
      n_chk++;
      if (joy !== e) begin
        n_fail++;
        $display("FAIL autofire[%0d]: got %h want %h", i, joy, e);
      end
`ifdef KBD_AUTOFIRE_EN
      exp_q.push_back(((i + 1) % 8) < 4 ? 13'h0010 : 13'h0000);
`else
      exp_q.push_back(13'h0010);
`endif
      @(negedge clk);
    end
    void'(exp_q.pop_front());
    strobe(8'hF0);
    exp_q.push_back(13'h0000);
    strobe(8'h29);
    e = exp_q.pop_front();
    n_chk++;
    if (joy !== e) begin
      n_fail++;
      $display("FAIL autofire_release: got %h want %h", joy, e);
    end
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    test_reset();
    test_make_break();
    test_extended();
    test_back_to_back_pause();
    test_hotplug_system();
    test_autofire();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
